bus_responder: RTL and testbench
================================

Name: bus_responder

Overview:
- Memory-side responder for the CPU external bus: the other end of the CPU's o_ad/o_tag/o_astb/o_rd/o_wr outputs and its i_data/i_tag inputs.
- Latches the address phase, performs tagged 64-bit writes, and returns read data and tag with a fixed, parameterised latency.
- Flags bus-protocol violations.
- Replaces the bare behavioural memory in CPU-level benches and serves as the reference slave for future external-bus work.

Parameters:
- ADDR_WIDTH, 20: word-address bits decoded from ad[19:0]; depth is 2**ADDR_WIDTH words.
- LATENCY, 1: read latency in cycles, legal range 1..4.
- AUTOINC, 0: when 1, the latched address increments after every accepted rd or wr.

Ports:
- clk  in  1: clock; all activity on the rising edge.
- reset  in  1: asynchronous, active-low reset.
- i_ad  in  64: address/data from CPU o_ad.
- i_tag  in  8: write tag from CPU o_tag.
- i_astb  in  1: address strobe.
- i_rd  in  1: read request.
- i_wr  in  1: write request.
- o_data  out  64: read data to CPU i_data.
- o_tag  out  8: read tag to CPU i_tag.
- o_valid  out  1: one-cycle pulse when o_data/o_tag are updated.
- o_perr  out  1: sticky protocol-error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - o_data=0, o_tag=0, o_valid=0, o_perr=0.
  - Read pipeline flushed; state=IDLE; latched address=0.
  - Memory contents are not cleared.
- States:
  - IDLE: no valid address.
  - ADDR: address latched.
  - IDLE -> ADDR on a legal i_astb. ADDR stays ADDR, and each new i_astb overwrites the address. Only reset returns to IDLE.
- Address phase: i_astb=1 with i_wr=0 latches addr=i_ad[ADDR_WIDTH-1:0]. Upper i_ad bits are ignored, so addresses wrap modulo depth.
- Write: i_wr=1 in ADDR state writes mem[addr] <= {i_tag, i_ad} at that edge.
- Read: i_rd=1 samples {tag,data}=mem[addr] at that edge.
  - The value travels LATENCY pipeline stages.
  - o_data/o_tag update and o_valid pulses exactly LATENCY cycles after the sampling edge.
  - Back-to-back reads, one per cycle, are accepted; throughput is 1/cycle.
  - o_data/o_tag hold their last value between reads.
- Address and read in the same cycle: i_astb=1 with i_rd=1 is legal. The new address i_ad[ADDR_WIDTH-1:0] is used for that read and is also latched.
- Ordering:
  - Write at edge N followed by a read at edge N+1 to the same address returns the new value.
  - A read sampled at edge N is unaffected by writes at edges after N.
- AUTOINC=1: after each accepted rd or wr, addr <= addr+1 modulo 2**ADDR_WIDTH. The increment applies after the access; when i_astb and i_rd coincide, the access uses the new address and then increments.
- Protocol errors set o_perr=1 until reset, and the offending access is ignored (no write, no read issued, address unchanged):
  - i_rd or i_wr in IDLE state.
  - i_rd=1 and i_wr=1 in the same cycle.
  - i_astb=1 and i_wr=1 in the same cycle (i_ad cannot carry both address and data).
- Reset mid-read: in-flight reads are discarded, and no o_valid pulse appears after reset is released.
- Data X on i_ad during an idle cycle (no strobe/rd/wr) has no effect.

Test Plan:
- Reset then idle 10 cycles -> o_data=0, o_tag=0, o_valid=0, o_perr=0 throughout.
- LATENCY=1: astb ad=0x00123; wr ad=0x0123456789ABCDEF tag=0x05; rd -> one cycle after the rd edge, o_data=0x0123456789ABCDEF, o_tag=0x05, single o_valid pulse; o_perr=0.
- LATENCY=3, AUTOINC=1:
  - Setup: astb ad=0x10; four writes with data 0xA0..0xA3 (tags 1..4); astb ad=0x10.
  - Stimulus: four consecutive rd cycles.
  - Response: o_valid high 4 consecutive cycles starting 3 cycles after the first rd; data 0xA0,0xA1,0xA2,0xA3; tags 1..4.
- Wrap: ADDR_WIDTH=20, AUTOINC=1; astb ad=0xFFFFF; wr 0x11; wr 0x22 -> reading addresses 0xFFFFF and 0x00000 returns 0x11 and 0x22.
- Errors:
  - rd before any astb -> o_perr=1, no o_valid.
  - After reset: astb+wr in the same cycle -> o_perr=1, and the address is not latched (state stays IDLE).
  - rd+wr in the same cycle after a legal astb -> o_perr=1 and the memory word is unchanged.
- Reset mid-read: LATENCY=4; rd issued, reset asserted 2 cycles later for 1 cycle -> no o_valid pulse ever, o_data=0.

Source files
------------

// File: rtl/bus_responder_if.sv
// CPU external-bus link: CPU-side address/data/strobes toward the responder, read data back.
interface bus_responder_if;
    logic [63:0] i_ad;
    logic [7:0]  i_tag;
    logic        i_astb;
    logic        i_rd;
    logic        i_wr;
    logic [63:0] o_data;
    logic [7:0]  o_tag;
    logic        o_valid;
    logic        o_perr;

    modport master (
        output i_ad, i_tag, i_astb, i_rd, i_wr,
        input  o_data, o_tag, o_valid, o_perr
    );

    modport slave (
        input  i_ad, i_tag, i_astb, i_rd, i_wr,
        output o_data, o_tag, o_valid, o_perr
    );
endinterface

// File: rtl/bus_responder.sv
// Memory-side responder for the CPU external bus: latched address, tagged 64-bit writes,
// fixed-latency tagged reads and a sticky protocol-error flag.
module bus_responder #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned LATENCY    = 1,
    parameter bit          AUTOINC    = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    bus_responder_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned WORD_W = DATA_W + TAG_W;
    // Stage 0 captures the word at the sampling edge; LATENCY further stages reach the outputs.
    localparam int unsigned STAGES = LATENCY + 1;

    typedef enum logic {IDLE, ADDR} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  perr_q, perr_d;
    logic                  err, rd_ok, wr_ok;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [WORD_W-1:0]     rd_word;
    logic [STAGES-1:0]     vld_q;
    logic [WORD_W-1:0]     dat_q [STAGES];

    // Access decode: an offending access is dropped entirely and only raises the error flag.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        acc_addr = addr_q;
        rd_ok    = 1'b0;
        wr_ok    = 1'b0;
        err      = (bus.i_rd && bus.i_wr)
                || (bus.i_astb && bus.i_wr)
                || ((bus.i_rd || bus.i_wr) && !bus.i_astb && (state_q == IDLE));
        perr_d   = perr_q | err;
        if (!err) begin
            if (bus.i_astb) begin
                acc_addr = bus.i_ad[ADDR_WIDTH-1:0];
                addr_d   = bus.i_ad[ADDR_WIDTH-1:0];
                state_d  = ADDR;
            end
            rd_ok = bus.i_rd;
            wr_ok = bus.i_wr;
            if (AUTOINC && (bus.i_rd || bus.i_wr)) begin
                addr_d = acc_addr + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            perr_q  <= perr_d;
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[acc_addr] <= {bus.i_tag, bus.i_ad};
        end
    end

    assign rd_word = mem[acc_addr];

    // Read pipeline; every stage holds its word when no read passes through, so outputs persist.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                dat_q[s] <= '0;
            end
        end else begin
            vld_q <= {vld_q[STAGES-2:0], rd_ok};
            if (rd_ok) begin
                dat_q[0] <= rd_word;
            end
            for (int unsigned s = 1; s < STAGES; s++) begin
                if (vld_q[s-1]) begin
                    dat_q[s] <= dat_q[s-1];
                end
            end
        end
    end

    assign bus.o_valid = vld_q[STAGES-1];
    assign bus.o_data  = dat_q[STAGES-1][DATA_W-1:0];
    assign bus.o_tag   = dat_q[STAGES-1][WORD_W-1:DATA_W];
    assign bus.o_perr  = perr_q;
endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: per-cycle vector table plus multi-cycle corner sequences.
module tb_bus_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        astb, rd, wr;
    logic [63:0] ad;
    logic [7:0]  tag;

    int unsigned total  = 0;
    int unsigned passed = 0;

    bus_responder_if ifa ();
    bus_responder_if ifb ();
    bus_responder_if ifc ();

    assign ifa.i_astb = astb; assign ifa.i_rd = rd; assign ifa.i_wr = wr;
    assign ifa.i_ad   = ad;   assign ifa.i_tag = tag;
    assign ifb.i_astb = astb; assign ifb.i_rd = rd; assign ifb.i_wr = wr;
    assign ifb.i_ad   = ad;   assign ifb.i_tag = tag;
    assign ifc.i_astb = astb; assign ifc.i_rd = rd; assign ifc.i_wr = wr;
    assign ifc.i_ad   = ad;   assign ifc.i_tag = tag;

    bus_responder #(.ADDR_WIDTH(20), .LATENCY(1), .AUTOINC(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    bus_responder #(.ADDR_WIDTH(20), .LATENCY(3), .AUTOINC(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    bus_responder #(.ADDR_WIDTH(8),  .LATENCY(4), .AUTOINC(1'b0)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    typedef struct packed {
        logic        astb;
        logic        rd;
        logic        wr;
        logic [63:0] ad;
        logic [7:0]  tag;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  et;
        logic        ep;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vt [NVEC];

    localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DX = {64{1'bx}};

    function automatic vec_t mk(logic a, logic r, logic w, logic [63:0] d, logic [7:0] t,
                                logic ev, logic [63:0] ed, logic [7:0] et, logic ep);
        vec_t v;
        v.astb = a; v.rd = r; v.wr = w; v.ad = d; v.tag = t;
        v.ev = ev; v.ed = ed; v.et = et; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic r, input logic w,
                         input logic [63:0] d, input logic [7:0] t);
        astb = a; rd = r; wr = w; ad = d; tag = t;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0]  = mk(0,0,0, DX,                     8'h00, 0, 64'h0,    8'h0, 0);
        vt[1]  = mk(1,0,0, 64'h123,                8'h00, 0, 64'h0,    8'h0, 0);
        vt[2]  = mk(0,0,1, D1,                     8'h05, 0, 64'h0,    8'h0, 0);
        vt[3]  = mk(0,1,0, 64'h0,                  8'h00, 0, 64'h0,    8'h0, 0);
        vt[4]  = mk(0,0,0, 64'h0,                  8'h00, 1, D1,       8'h5, 0);
        vt[5]  = mk(0,0,0, 64'h0,                  8'h00, 0, D1,       8'h5, 0);
        vt[6]  = mk(1,1,0, 64'hFFF0_0000_0000_0123, 8'h00, 0, D1,       8'h5, 0);
        vt[7]  = mk(0,0,0, 64'h0,                  8'h00, 1, D1,       8'h5, 0);
        vt[8]  = mk(0,0,1, 64'hDEAD,               8'h07, 0, D1,       8'h5, 0);
        vt[9]  = mk(0,1,0, 64'h0,                  8'h00, 0, D1,       8'h5, 0);
        vt[10] = mk(0,0,0, 64'h0,                  8'h00, 1, 64'hDEAD, 8'h7, 0);
        vt[11] = mk(1,0,0, 64'h200,                8'h00, 0, 64'hDEAD, 8'h7, 0);
        vt[12] = mk(0,0,1, 64'hBEEF,               8'h09, 0, 64'hDEAD, 8'h7, 0);
        vt[13] = mk(1,1,0, 64'h123,                8'h00, 0, 64'hDEAD, 8'h7, 0);
        vt[14] = mk(1,1,0, 64'h200,                8'h00, 1, 64'hDEAD, 8'h7, 0);
        vt[15] = mk(0,0,0, 64'h0,                  8'h00, 1, 64'hBEEF, 8'h9, 0);
        vt[16] = mk(0,0,0, 64'h0,                  8'h00, 0, 64'hBEEF, 8'h9, 0);
        vt[17] = mk(0,1,1, 64'h1111,               8'h01, 0, 64'hBEEF, 8'h9, 1);
        vt[18] = mk(0,1,0, 64'h0,                  8'h00, 0, 64'hBEEF, 8'h9, 1);
        vt[19] = mk(0,0,0, 64'h0,                  8'h00, 1, 64'hBEEF, 8'h9, 1);
        vt[20] = mk(1,0,1, 64'h123,                8'h02, 0, 64'hBEEF, 8'h9, 1);
        vt[21] = mk(0,1,0, 64'h0,                  8'h00, 0, 64'hBEEF, 8'h9, 1);
        vt[22] = mk(0,0,0, 64'h0,                  8'h00, 1, 64'hBEEF, 8'h9, 1);

        // Reset, then 10 quiet cycles with all outputs at their reset values.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle%0d valid", i), 64'(ifa.o_valid), 64'h0);
            chk($sformatf("idle%0d data", i),  ifa.o_data,       64'h0);
            chk($sformatf("idle%0d tag", i),   64'(ifa.o_tag),   64'h0);
            chk($sformatf("idle%0d perr", i),  64'(ifa.o_perr),  64'h0);
        end
        chk("idle b data", ifb.o_data, 64'h0);
        chk("idle c data", ifc.o_data, 64'h0);

        // Cycle-by-cycle vectors on the LATENCY=1, non-incrementing responder.
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            drive(vt[i].astb, vt[i].rd, vt[i].wr, vt[i].ad, vt[i].tag);
            tick();
            chk($sformatf("vec%0d valid", i), 64'(ifa.o_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d data", i),  ifa.o_data,       vt[i].ed);
            chk($sformatf("vec%0d tag", i),   64'(ifa.o_tag),   64'(vt[i].et));
            chk($sformatf("vec%0d perr", i),  64'(ifa.o_perr),  64'(vt[i].ep));
        end

        // Read before any address strobe.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        chk("rd_idle perr", 64'(ifa.o_perr), 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rd_idle valid%0d", i), 64'(ifa.o_valid), 64'h0);
        end

        // Strobe with write must not latch the address: the following read stays illegal.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 64'h55, 8'h3);
        tick();
        chk("astb_wr perr", 64'(ifa.o_perr), 64'h1);
        drive(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("astb_wr valid%0d", i), 64'(ifa.o_valid), 64'h0);
        end

        // Burst on LATENCY=3 with auto-increment.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 64'h10, 8'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 64'hA0 + 64'(i), 8'(i + 1));
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 64'h10, 8'h0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, k < 4, 1'b0, 64'h0, 8'h0);
            tick();
            chk($sformatf("burst%0d valid", k), 64'(ifb.o_valid), 64'((k >= 3) && (k <= 6)));
            if (k >= 3 && k <= 6) begin
                chk($sformatf("burst%0d data", k), ifb.o_data, 64'hA0 + 64'(k - 3));
                chk($sformatf("burst%0d tag", k), 64'(ifb.o_tag), 64'(k - 2));
            end
        end
        chk("burst perr", 64'(ifb.o_perr), 64'h0);

        // Address wrap at the top of the 20-bit space.
        drive(1'b1, 1'b0, 1'b0, 64'hFFFFF, 8'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 64'h11, 8'h1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 64'h22, 8'h2);
        tick();
        for (int k = 0; k < 7; k++) begin
            drive(k == 0, k < 2, 1'b0, 64'hFFFFF, 8'h0);
            tick();
            chk($sformatf("wrap%0d valid", k), 64'(ifb.o_valid), 64'((k == 3) || (k == 4)));
            if (k == 3) chk("wrap top data", ifb.o_data, 64'h11);
            if (k == 4) chk("wrap zero data", ifb.o_data, 64'h22);
        end
        chk("wrap perr", 64'(ifb.o_perr), 64'h0);

        // LATENCY=4 read timing, then reset with a read in flight.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 64'h5, 8'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 64'h77, 8'h3);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, k == 0, 1'b0, 64'h0, 8'h0);
            tick();
            chk($sformatf("lat4_%0d valid", k), 64'(ifc.o_valid), 64'(k == 4));
        end
        chk("lat4 data", ifc.o_data, 64'h77);
        chk("lat4 tag", 64'(ifc.o_tag), 64'h3);
        drive(1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrst data", ifc.o_data, 64'h0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("midrst%0d valid", k), 64'(ifc.o_valid), 64'h0);
            chk($sformatf("midrst%0d data", k),  ifc.o_data,       64'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
